// File: rtl/pe_mem_dispatcher_pkg.sv
// Shared definitions for the PE memory-load bus: CTRL_PE field layout, pack/unpack helpers
// and the dispatcher state encoding.
package pe_mem_dispatcher_pkg;

    localparam int CTRL_PE_ID_W  = 2;
    localparam int CTRL_NS_W     = 2;
    localparam int CTRL_W        = CTRL_PE_ID_W + 1 + CTRL_NS_W;

    // CTRL_PE = {pe_id, valid, namespace_id}, MSB to LSB
    localparam int CTRL_NS_LSB    = 0;
    localparam int CTRL_VALID_BIT = CTRL_NS_W;
    localparam int CTRL_PE_ID_LSB = CTRL_NS_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic logic [CTRL_W-1:0] pack_ctrl_pe(
        input logic [CTRL_PE_ID_W-1:0] pe_id,
        input logic                    valid,
        input logic [CTRL_NS_W-1:0]    ns
    );
        return {pe_id, valid, ns};
    endfunction

    function automatic logic ctrl_pe_valid(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_VALID_BIT];
    endfunction

    function automatic logic [CTRL_PE_ID_W-1:0] ctrl_pe_id(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_PE_ID_LSB +: CTRL_PE_ID_W];
    endfunction

endpackage

// File: rtl/pe_mem_dispatcher.sv
// Transmit side of the PE memory-load interface: spreads an accepted word stream
// round-robin over NUM_PE PEs for WORDS_PER_PE rounds, then pulses DONE.
module pe_mem_dispatcher
    import pe_mem_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_PE          = 4,
    parameter int PE_ID_WIDTH     = CTRL_PE_ID_W,
    parameter int NAMESPACE_WIDTH = CTRL_NS_W,
    parameter int CTRL_PE_WIDTH   = PE_ID_WIDTH + 1 + NAMESPACE_WIDTH,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       START,
    input  logic [NAMESPACE_WIDTH-1:0] NAMESPACE,
    input  logic [COUNT_WIDTH-1:0]     WORDS_PER_PE,
    input  logic [DATA_WIDTH-1:0]      S_DATA,
    input  logic                       S_VALID,
    output logic                       S_READY,
    output logic [DATA_WIDTH-1:0]      DATA_OUT,
    output logic [CTRL_PE_WIDTH-1:0]   CTRL_PE,
    output logic                       BUSY,
    output logic                       DONE
);

    localparam logic [PE_ID_WIDTH-1:0] LAST_PE = PE_ID_WIDTH'(NUM_PE - 1);

    state_t                     state;
    state_t                     state_next;
    logic [PE_ID_WIDTH-1:0]     pe_idx;
    logic [COUNT_WIDTH-1:0]     round_cnt;
    logic [COUNT_WIDTH-1:0]     words_q;
    logic [NAMESPACE_WIDTH-1:0] ns_q;
    logic [DATA_WIDTH-1:0]      data_q;
    logic [CTRL_PE_WIDTH-1:0]   ctrl_q;
    logic                       done_q;
    logic                       accept;
    logic                       last_pe;
    logic                       last_word;

    // Handshake: a word transfers on any cycle where S_VALID and S_READY are both high;
    // S_READY depends only on state, never on S_VALID.
    assign S_READY   = (state == LOAD);
    assign accept    = S_VALID && S_READY;
    // Wrap is an explicit compare so non-power-of-2 NUM_PE never reaches an unused pe_id.
    assign last_pe   = (pe_idx == LAST_PE);
    assign last_word = accept && last_pe && (round_cnt == (words_q - COUNT_WIDTH'(1)));

    assign DATA_OUT  = data_q;
    assign CTRL_PE   = ctrl_q;
    assign BUSY      = (state != IDLE);
    assign DONE      = done_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (START) begin
                    state_next = (WORDS_PER_PE == '0) ? FIN : LOAD;
                end
            end
            LOAD: begin
                if (last_word) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state     <= IDLE;
            pe_idx    <= '0;
            round_cnt <= '0;
            words_q   <= '0;
            ns_q      <= '0;
            data_q    <= '0;
            ctrl_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= (state_next == FIN);
            ctrl_q <= accept ? {pe_idx, 1'b1, ns_q} : '0;
            if (accept) begin
                data_q <= S_DATA;
            end
            if ((state == IDLE) && START) begin
                ns_q      <= NAMESPACE;
                words_q   <= WORDS_PER_PE;
                pe_idx    <= '0;
                round_cnt <= '0;
            end else if (accept) begin
                if (last_pe) begin
                    pe_idx    <= '0;
                    round_cnt <= round_cnt + COUNT_WIDTH'(1);
                end else begin
                    pe_idx <= pe_idx + PE_ID_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_mem_dispatcher.sv
// Directed bench for pe_mem_dispatcher: a 4-PE instance for most scenarios and a 3-PE
// instance for the non-power-of-2 wrap.
module tb_pe_mem_dispatcher;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start, start3;
    logic [1:0]  ns;
    logic [15:0] wpp;
    logic [15:0] s_data;
    logic        s_valid, s_valid3;

    logic        s_ready, s_ready3;
    logic [15:0] data_out, data_out3;
    logic [4:0]  ctrl_pe, ctrl_pe3;
    logic        busy, busy3;
    logic        done, done3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 aclk = ~aclk;

    pe_mem_dispatcher #(.NUM_PE(4)) dut (
        .ACLK(aclk), .ARESETN(aresetn), .START(start), .NAMESPACE(ns),
        .WORDS_PER_PE(wpp), .S_DATA(s_data), .S_VALID(s_valid), .S_READY(s_ready),
        .DATA_OUT(data_out), .CTRL_PE(ctrl_pe), .BUSY(busy), .DONE(done)
    );

    pe_mem_dispatcher #(.NUM_PE(3)) dut3 (
        .ACLK(aclk), .ARESETN(aresetn), .START(start3), .NAMESPACE(ns),
        .WORDS_PER_PE(wpp), .S_DATA(s_data), .S_VALID(s_valid3), .S_READY(s_ready3),
        .DATA_OUT(data_out3), .CTRL_PE(ctrl_pe3), .BUSY(busy3), .DONE(done3)
    );

    // Drives one whole load cycle by cycle (inputs changed and outputs sampled on the
    // falling edge) and checks every cycle against a word-count model.
    task automatic run_load(input string tag, input bit use3, input int n_wpp,
                            input logic [1:0] load_ns, input bit stall, input int restart_at,
                            input logic [1:0] ns_after, input logic [15:0] base);
        int          npe, total, sent, prev_pe;
        bit          prev_acc, fin_seen, finished, restarted, acc, v;
        bit          exp_rdy, exp_done, exp_busy;
        logic [15:0] prev_data, dt;
        logic [4:0]  ct, exp_ct;
        logic        rdy, dn, bs;
        npe = use3 ? 3 : 4;
        total = npe * n_wpp;
        ns = load_ns;
        wpp = n_wpp[15:0];
        if (use3) start3 = 1'b1; else start = 1'b1;
        @(negedge aclk);
        start = 1'b0; start3 = 1'b0;
        ns = ns_after;
        wpp = 16'd7;
        sent = 0; prev_pe = 0; prev_acc = 0; prev_data = '0;
        fin_seen = 0; finished = 0; restarted = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            rdy = use3 ? s_ready3  : s_ready;
            ct  = use3 ? ctrl_pe3  : ctrl_pe;
            dt  = use3 ? data_out3 : data_out;
            dn  = use3 ? done3     : done;
            bs  = use3 ? busy3     : busy;
            exp_done = (total == 0) ? (cyc == 0) : (prev_acc && sent == total);
            exp_rdy  = (total != 0) && (sent < total);
            exp_busy = exp_rdy || exp_done;
            exp_ct   = prev_acc ? {prev_pe[1:0], 1'b1, load_ns} : 5'd0;
            n_checks++;
            if (rdy !== exp_rdy) begin
                n_errors++;
                $display("FAIL %s s_ready cyc=%0d got=%b exp=%b", tag, cyc, rdy, exp_rdy);
            end
            n_checks++;
            if (ct !== exp_ct) begin
                n_errors++;
                $display("FAIL %s ctrl_pe cyc=%0d got=%b exp=%b", tag, cyc, ct, exp_ct);
            end
            n_checks++;
            if (dn !== exp_done) begin
                n_errors++;
                $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, cyc, dn, exp_done);
            end
            n_checks++;
            if (bs !== exp_busy) begin
                n_errors++;
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, cyc, bs, exp_busy);
            end
            if (prev_acc) begin
                n_checks++;
                if (dt !== prev_data) begin
                    n_errors++;
                    $display("FAIL %s data_out cyc=%0d got=%h exp=%h", tag, cyc, dt, prev_data);
                end
            end
            if (fin_seen) begin
                finished = 1;
                break;
            end
            fin_seen = exp_done;
            // Keep offering words even after the load ends; none may be taken.
            v = !(stall && cyc[0]);
            s_data = base + sent[15:0];
            if (use3) s_valid3 = v; else s_valid = v;
            acc = v && exp_rdy;
            start = 1'b0;
            if (restart_at >= 0 && sent == restart_at && !restarted) begin
                start = 1'b1;
                wpp = 16'd1;
                restarted = 1;
            end
            if (acc) begin
                prev_pe = sent % npe;
                prev_data = base + sent[15:0];
                sent++;
            end
            prev_acc = acc;
            @(negedge aclk);
        end
        s_valid = 1'b0; s_valid3 = 1'b0; start = 1'b0;
        n_checks++;
        if (!finished) begin
            n_errors++;
            $display("FAIL %s timeout got=%0d words exp=%0d", tag, sent, total);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        n_checks++;
        if ({s_ready, data_out, ctrl_pe, busy, done} !== 24'd0) begin
            n_errors++;
            $display("FAIL reset outputs got=%h exp=0", {s_ready, data_out, ctrl_pe, busy, done});
        end
        n_checks++;
        if ({s_ready3, data_out3, ctrl_pe3, busy3, done3} !== 24'd0) begin
            n_errors++;
            $display("FAIL reset3 outputs got=%h exp=0", {s_ready3, data_out3, ctrl_pe3, busy3, done3});
        end
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_basic();
        run_load("basic", 1'b0, 2, 2'd2, 1'b0, -1, 2'd2, 16'h0010);
    endtask

    task automatic test_stall();
        run_load("stall", 1'b0, 2, 2'd2, 1'b1, -1, 2'd2, 16'h0010);
    endtask

    task automatic test_zero_count();
        run_load("zero", 1'b0, 0, 2'd1, 1'b0, -1, 2'd1, 16'h0020);
    endtask

    task automatic test_restart_ignored();
        run_load("restart", 1'b0, 2, 2'd0, 1'b0, 3, 2'd0, 16'h0030);
    endtask

    task automatic test_config_latch();
        run_load("latch", 1'b0, 2, 2'd1, 1'b0, -1, 2'd3, 16'h0050);
    endtask

    task automatic test_wrap3();
        run_load("wrap3", 1'b1, 2, 2'd3, 1'b0, -1, 2'd3, 16'h0060);
    endtask

    task automatic test_mid_reset();
        logic [4:0] exp_ct;
        ns = 2'd1; wpp = 16'd2; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data = 16'h0040 + 16'(i);
            @(negedge aclk);
            exp_ct = {2'(i % 4), 1'b1, 2'd1};
            n_checks++;
            if (ctrl_pe !== exp_ct) begin
                n_errors++;
                $display("FAIL midrst ctrl_pe word=%0d got=%b exp=%b", i, ctrl_pe, exp_ct);
            end
        end
        // A sixth word is on offer as reset hits; it must not appear.
        s_data = 16'h0045;
        aresetn = 1'b0;
        @(negedge aclk);
        n_checks++;
        if ({s_ready, data_out, ctrl_pe, busy, done} !== 24'd0) begin
            n_errors++;
            $display("FAIL midrst outputs got=%h exp=0", {s_ready, data_out, ctrl_pe, busy, done});
        end
        aresetn = 1'b1;
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            n_checks++;
            if ({done, busy, ctrl_pe} !== 7'd0) begin
                n_errors++;
                $display("FAIL midrst idle cyc=%0d got=%b exp=0", i, {done, busy, ctrl_pe});
            end
        end
        run_load("after_rst", 1'b0, 1, 2'd2, 1'b0, -1, 2'd2, 16'h0070);
    endtask

    initial begin
        aresetn = 1'b0;
        start = 1'b0; start3 = 1'b0;
        ns = '0; wpp = '0; s_data = '0;
        s_valid = 1'b0; s_valid3 = 1'b0;
        @(negedge aclk);
        test_reset();
        test_basic();
        test_stall();
        test_zero_count();
        test_restart_ignored();
        test_mid_reset();
        test_config_latch();
        test_wrap3();
        repeat (2) @(negedge aclk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
